// File: rtl/itch_pkg.sv
// Shared constants and types for the ITCH message dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package itch_pkg;

  localparam int NUM_TYPES       = 6;
  localparam int DEF_MIN_MSG_LEN = 9;

  // Type bytes of the messages that have a downstream parser.
  localparam logic [7:0] TYPE_A = 8'h41;
  localparam logic [7:0] TYPE_C = 8'h43;
  localparam logic [7:0] TYPE_E = 8'h45;
  localparam logic [7:0] TYPE_D = 8'h44;
  localparam logic [7:0] TYPE_U = 8'h55;
  localparam logic [7:0] TYPE_P = 8'h50;

  // Bit position of each type inside start_vec.
  localparam int IDX_A = 0;
  localparam int IDX_C = 1;
  localparam int IDX_E = 2;
  localparam int IDX_D = 3;
  localparam int IDX_U = 4;
  localparam int IDX_P = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/itch_msg_dispatcher_if.sv
// Stream bundle between the packet source, the dispatcher and the field parsers.
// Latency: n/a (wiring only).
// Backpressure: none; the source streams words qualified by data_valid.
interface itch_msg_dispatcher_if;
  import itch_pkg::*;

  logic [63:0]          data_in;
  logic                 data_valid;
  logic                 data_last;
  logic [63:0]          data_out;
  logic                 data_out_valid;
  logic [NUM_TYPES-1:0] start_vec;
  logic [7:0]           msg_type;
  logic [5:0]           tracker_out;
  logic                 len_err;
  logic                 trunc_err;
  logic                 busy;

  modport master (
    output data_in, data_valid, data_last,
    input  data_out, data_out_valid, start_vec, msg_type, tracker_out,
           len_err, trunc_err, busy
  );

  modport slave (
    input  data_in, data_valid, data_last,
    output data_out, data_out_valid, start_vec, msg_type, tracker_out,
           len_err, trunc_err, busy
  );

endinterface

// File: rtl/itch_type_decode.sv
// Maps an ITCH type byte to its one-hot parser select plus a known flag.
// Latency: combinational.
// Backpressure: none.
module itch_type_decode
  import itch_pkg::*;
(
  input  logic [7:0]           typeByte,
  output logic [NUM_TYPES-1:0] oneHot,
  output logic                 known
);

  // Table lookup; anything not listed selects no parser.
  always_comb begin
    oneHot = '0;
    case (typeByte)
      TYPE_A:  oneHot[IDX_A] = 1'b1;
      TYPE_C:  oneHot[IDX_C] = 1'b1;
      TYPE_E:  oneHot[IDX_E] = 1'b1;
      TYPE_D:  oneHot[IDX_D] = 1'b1;
      TYPE_U:  oneHot[IDX_U] = 1'b1;
      TYPE_P:  oneHot[IDX_P] = 1'b1;
      default: oneHot = '0;
    endcase
    known = |oneHot;
  end

endmodule

// File: rtl/itch_msg_dispatcher.sv
// Finds ITCH message boundaries in a 64-bit packet stream, decodes type, emits start level + bit offset.
// Latency: 1 cycle, data_in to data_out with start_vec/tracker_out aligned to the same word.
// Backpressure: none; all state advances only on data_valid. ITCH_DISPATCH_STATS_EN adds counters.
module itch_msg_dispatcher
  import itch_pkg::*;
#(
  parameter int MIN_MSG_LEN = DEF_MIN_MSG_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  itch_msg_dispatcher_if.slave bus
`ifdef ITCH_DISPATCH_STATS_EN
  ,
  output logic [31:0]          msg_cnt,
  output logic [31:0]          unknown_cnt,
  output logic [15:0]          err_cnt
`endif
);

  // Parse state carried between words.
  state_t               state;
  logic [2:0]           ptr;
  logic [1:0]           hdrCnt;
  logic [15:0]          rem;
  logic [7:0]           lenHold;
  // A type byte that landed on byte 7: its start shows with the next word.
  logic                 pendQ;
  logic [NUM_TYPES-1:0] pendVec;
  logic [7:0]           pendType;
  // Next word still carries payload of the message on start_vec.
  logic                 liveQ;

  // Output registers.
  logic [63:0]          dataOut;
  logic                 dataOutVld;
  logic [NUM_TYPES-1:0] startVec;
  logic [7:0]           msgType;
  logic [5:0]           tracker;
  logic                 lenErr;
  logic                 truncErr;

  // Per-word parse results.
  state_t               nState;
  logic [3:0]           nPtr;
  logic [1:0]           nHdrCnt;
  logic [15:0]          nRem;
  logic [7:0]           nLenHold;
  logic [15:0]          lenWord;
  logic [3:0]           avail;
  logic [7:0]           curByte;
  logic                 restNz;
  logic                 typeSeen;
  logic [7:0]           typeByte;
  logic                 startNow;
  logic [2:0]           startByte;
  logic                 pendNext;
  logic                 lenBad;
  logic                 truncNow;
  logic                 bodySeen;

  logic [NUM_TYPES-1:0] typeHot;
  logic                 typeKnown;

  itch_type_decode u_typeDecode (
    .typeByte (typeByte),
    .oneHot   (typeHot),
    .known    (typeKnown)
  );

  // Walk one word: finish the open body, then header bytes, then count the new body's first bytes.
  always_comb begin
    nState    = state;
    nPtr      = {1'b0, ptr};
    nHdrCnt   = hdrCnt;
    nRem      = rem;
    nLenHold  = lenHold;
    lenWord   = '0;
    avail     = '0;
    curByte   = '0;
    restNz    = 1'b0;
    typeSeen  = 1'b0;
    typeByte  = '0;
    startNow  = 1'b0;
    startByte = '0;
    pendNext  = 1'b0;
    lenBad    = 1'b0;
    truncNow  = 1'b0;
    bodySeen  = 1'b0;

    if (nState == IDLE) begin
      nState  = HDR;
      nPtr    = 4'd0;
      nHdrCnt = 2'd3;
    end

    if (nState == FLUSH) begin
      if (bus.data_last) nState = IDLE;
    end else begin
      if (nState == BODY) begin
        bodySeen = 1'b1;
        avail    = 4'd8 - nPtr;
        if (nRem > {12'd0, avail}) begin
          nRem = nRem - {12'd0, avail};
          nPtr = 4'd8;
        end else begin
          nPtr    = nPtr + nRem[3:0];
          nRem    = '0;
          nState  = HDR;
          nHdrCnt = 2'd3;
        end
      end

      // Anything non-zero after a message boundary in the last word is a real header, not padding.
      for (int i = 0; i < 8; i++) begin
        if (4'(i) >= nPtr && bus.data_in[8*i +: 8] != 8'h00) restNz = 1'b1;
      end

      if (bus.data_last && nState == HDR && nHdrCnt == 2'd3 && !restNz) begin
        nState = IDLE;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (nState == HDR && nHdrCnt != 2'd0 && nPtr < 4'd8) begin
            curByte = bus.data_in[{nPtr[2:0], 3'b000} +: 8];
            case (nHdrCnt)
              2'd3: begin
                nLenHold = curByte;
                nHdrCnt  = 2'd2;
              end
              2'd2: begin
                lenWord = {nLenHold, curByte};
                nHdrCnt = 2'd1;
                if (lenWord < 16'(MIN_MSG_LEN)) begin
                  lenBad = 1'b1;
                  nState = FLUSH;
                end else begin
                  nRem = lenWord - 16'd1;
                end
              end
              default: begin
                typeByte = curByte;
                typeSeen = 1'b1;
                nHdrCnt  = 2'd0;
                nState   = BODY;
              end
            endcase
            nPtr = nPtr + 4'd1;
          end
        end

        // Payload never fits in the header's word (length >= MIN_MSG_LEN), so just consume the tail.
        if (typeSeen) begin
          if (nPtr < 4'd8) begin
            startNow  = 1'b1;
            startByte = nPtr[2:0];
            avail     = 4'd8 - nPtr;
            nRem      = nRem - {12'd0, avail};
            nPtr      = 4'd8;
          end else begin
            pendNext = 1'b1;
          end
        end

        if (bus.data_last) begin
          truncNow = !lenBad;
          nState   = IDLE;
          pendNext = 1'b0;
        end
      end
    end

    if (nPtr == 4'd8) nPtr = 4'd0;
  end

  // Parse state advances only on valid words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hdrCnt   <= '0;
      rem      <= '0;
      lenHold  <= '0;
      pendQ    <= 1'b0;
      pendVec  <= '0;
      pendType <= '0;
      liveQ    <= 1'b0;
    end else if (bus.data_valid) begin
      state   <= nState;
      ptr     <= nPtr[2:0];
      hdrCnt  <= nHdrCnt;
      rem     <= nRem;
      lenHold <= nLenHold;
      pendQ   <= pendNext;
      if (pendNext) begin
        pendVec  <= typeKnown ? typeHot : '0;
        pendType <= typeByte;
      end
      liveQ <= (nState == BODY) && !pendNext;
    end
  end

  // Output word plus the start/tracker view that goes with it; a new payload start wins over an ending one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut    <= '0;
      dataOutVld <= 1'b0;
      startVec   <= '0;
      msgType    <= '0;
      tracker    <= '0;
      lenErr     <= 1'b0;
      truncErr   <= 1'b0;
    end else if (bus.data_valid) begin
      dataOut    <= bus.data_in;
      dataOutVld <= 1'b1;
      lenErr     <= lenBad;
      truncErr   <= truncNow;
      if (startNow) begin
        startVec <= typeKnown ? typeHot : '0;
        tracker  <= {startByte, 3'b000};
        msgType  <= typeByte;
      end else if (pendQ) begin
        startVec <= pendVec;
        tracker  <= '0;
        msgType  <= pendType;
      end else if (!bodySeen) begin
        startVec <= '0;
      end
    end else begin
      dataOutVld <= 1'b0;
      lenErr     <= 1'b0;
      truncErr   <= 1'b0;
      if (!liveQ) startVec <= '0;
    end
  end

  assign bus.data_out       = dataOut;
  assign bus.data_out_valid = dataOutVld;
  assign bus.start_vec      = startVec;
  assign bus.msg_type       = msgType;
  assign bus.tracker_out    = tracker;
  assign bus.len_err        = lenErr;
  assign bus.trunc_err      = truncErr;
  assign bus.busy           = (state != IDLE);

`ifdef ITCH_DISPATCH_STATS_EN
  // Saturating message, unknown-type and error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_cnt     <= '0;
      unknown_cnt <= '0;
      err_cnt     <= '0;
    end else if (bus.data_valid) begin
      if (typeSeen && msg_cnt != '1) msg_cnt <= msg_cnt + 32'd1;
      if (typeSeen && !typeKnown && unknown_cnt != '1) unknown_cnt <= unknown_cnt + 32'd1;
      if ((lenBad || truncNow) && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
